router_ack_credit_bank: RTL

Parametrised per-virtual-channel acknowledge/credit tracker for the router_wrap slice. It generalises the single registered IACK flag into a bank of NUM_VC credit counters. Downstream acknowledge pulses are registered through a configurable pipeline, and the block tracks how many buffer slots remain per VC. It sits between the slice's flit send logic and the incoming IACK lines, gating sends and flagging protocol errors.

---
 rtl/router_ack_credit_bank.sv | 99 +++++++++
 1 files changed

// File: rtl/router_ack_credit_bank.sv
// Per-VC credit bank: tracks free downstream buffer slots, gates flit sends
// and records sticky overflow/underflow protocol errors.
module router_ack_credit_bank #(
    parameter int NUM_VC   = 4,
    parameter int DEPTH    = 4,
    parameter int ACK_PIPE = 1,
    parameter int CW       = $clog2(DEPTH + 1),
    parameter int VCW      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_VC-1:0]    ack_in,
    input  logic                 send_valid,
    input  logic [VCW-1:0]       send_vc,
    output logic                 send_accept,
    output logic [NUM_VC-1:0]    vc_avail,
    output logic [NUM_VC*CW-1:0] credit_cnt,
    output logic                 err_ovf,
    output logic                 err_udf,
    input  logic                 clear_err
);

    logic [CW-1:0]     credit     [NUM_VC];
    logic [CW-1:0]     credit_nxt [NUM_VC];
    logic [NUM_VC-1:0] ack_eff;
    logic              vc_ok;
    logic              sel_nz;
    logic              sel_hit;
    logic              ovf_hit;
    logic              udf_hit;

    generate
        if (ACK_PIPE == 0) begin : g_no_pipe
            assign ack_eff = ack_in;
        end else begin : g_pipe
            logic [NUM_VC-1:0] stage [ACK_PIPE];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < ACK_PIPE; k++) stage[k] <= '0;
                end else begin
                    stage[0] <= ack_in;
                    for (int k = 1; k < ACK_PIPE; k++) stage[k] <= stage[k-1];
                end
            end
            assign ack_eff = stage[ACK_PIPE-1];
        end
    endgenerate

    // Handshake: a send transfers in any cycle where send_valid && send_accept
    // at the rising edge; send_accept never depends on credit returned that edge.
    always_comb begin
        vc_ok  = 32'(send_vc) < NUM_VC;
        sel_nz = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (send_vc == VCW'(i)) sel_nz = (credit[i] != '0);
        end
        send_accept = send_valid && vc_ok && sel_nz;
        udf_hit     = send_valid && !send_accept;
    end

    // An ack and a send on the same VC cancel, so a full VC does not overflow.
    always_comb begin
        ovf_hit = 1'b0;
        sel_hit = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            sel_hit       = send_accept && (send_vc == VCW'(i));
            credit_nxt[i] = credit[i];
            if (ack_eff[i] && !sel_hit) begin
                if (credit[i] == CW'(DEPTH)) ovf_hit = 1'b1;
                else                         credit_nxt[i] = credit[i] + CW'(1);
            end else if (!ack_eff[i] && sel_hit) begin
                credit_nxt[i] = credit[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VC; i++) credit[i] <= CW'(DEPTH);
            vc_avail <= '1;
            err_ovf  <= 1'b0;
            err_udf  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                credit[i]   <= credit_nxt[i];
                vc_avail[i] <= (credit_nxt[i] != '0);
            end
            err_ovf <= ovf_hit | (err_ovf & ~clear_err);
            err_udf <= udf_hit | (err_udf & ~clear_err);
        end
    end

    generate
        for (genvar g = 0; g < NUM_VC; g++) begin : g_cnt
            assign credit_cnt[g*CW +: CW] = credit[g];
        end
    endgenerate

endmodule
